// File: rtl/march_bist_ctrl.sv
// March C- BIST controller for a single-port memory with one-cycle registered read latency.
// Issues one memory op per cycle and records the first read mismatch.
module march_bist_ctrl #(
    parameter int a_width = 4,
    parameter int width   = 4,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [a_width-1:0] fail_addr,
    output logic [2:0]         fail_elem,
    output logic [width-1:0]   fail_data,
    output logic               mem_read,
    output logic               mem_write,
    output logic [a_width-1:0] mem_address,
    output logic [width-1:0]   mem_data_in,
    input  logic [width-1:0]   mem_data_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [a_width-1:0] addr_max = a_width'(depth - 1);

    state_t             state_q, state_d;
    logic [2:0]         elem_q, elem_d;
    logic [a_width-1:0] addr_q, addr_d;
    logic               phase_q, phase_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               fail_q, fail_d;
    logic [a_width-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]         fail_elem_q, fail_elem_d;
    logic [width-1:0]   fail_data_q, fail_data_d;
    logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [a_width-1:0] mem_address_q, mem_address_d;
    logic [width-1:0]   mem_data_in_q, mem_data_in_d;
    logic               chk_valid_q, chk_valid_d;
    logic [width-1:0]   chk_exp_q, chk_exp_d;
    logic [a_width-1:0] chk_addr_q, chk_addr_d;
    logic [2:0]         chk_elem_q, chk_elem_d;
    logic               last_addr, op_last, start_accept, run_d, op_read, mismatch;

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic is_two_op(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic read_ones(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    function automatic logic write_ones(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            elem_q        <= '0;
            addr_q        <= '0;
            phase_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_addr_q   <= '0;
            fail_elem_q   <= '0;
            fail_data_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            chk_valid_q   <= 1'b0;
            chk_exp_q     <= '0;
            chk_addr_q    <= '0;
            chk_elem_q    <= '0;
        end else begin
            state_q       <= state_d;
            elem_q        <= elem_d;
            addr_q        <= addr_d;
            phase_q       <= phase_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            fail_addr_q   <= fail_addr_d;
            fail_elem_q   <= fail_elem_d;
            fail_data_q   <= fail_data_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            chk_valid_q   <= chk_valid_d;
            chk_exp_q     <= chk_exp_d;
            chk_addr_q    <= chk_addr_d;
            chk_elem_q    <= chk_elem_d;
        end
    end

    // elem_q/addr_q/phase_q describe the op currently presented on the mem_* outputs.
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        addr_d       = addr_q;
        phase_d      = phase_q;
        start_accept = 1'b0;
        last_addr    = is_down(elem_q) ? (addr_q == '0) : (addr_q == addr_max);
        op_last      = !is_two_op(elem_q) || phase_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = ST_RUN;
                    elem_d       = 3'd0;
                    addr_d       = '0;
                    phase_d      = 1'b0;
                end
            end
            ST_RUN: begin
                if (!op_last) begin
                    phase_d = 1'b1;
                end else if (!last_addr) begin
                    phase_d = 1'b0;
                    addr_d  = is_down(elem_q) ? addr_q - a_width'(1) : addr_q + a_width'(1);
                end else if (elem_q == 3'd5) begin
                    state_d = ST_DRAIN;
                end else begin
                    elem_d  = elem_q + 3'd1;
                    phase_d = 1'b0;
                    addr_d  = is_down(elem_q + 3'd1) ? addr_max : '0;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run_d         = (state_d == ST_RUN);
        op_read       = (elem_d != 3'd0) && !phase_d;
        busy_d        = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d        = (state_d == ST_DONE);
        mem_read_d    = run_d && op_read;
        mem_write_d   = run_d && !op_read;
        mem_address_d = run_d ? addr_d : '0;
        mem_data_in_d = (mem_write_d && write_ones(elem_d)) ? {width{1'b1}} : '0;
        // Expected-data pipeline lines up with the memory's one-cycle read latency.
        chk_valid_d   = mem_read_q;
        chk_exp_d     = read_ones(elem_q) ? {width{1'b1}} : '0;
        chk_addr_d    = mem_address_q;
        chk_elem_d    = elem_q;
        mismatch      = chk_valid_q && (mem_data_out != chk_exp_q);
        fail_d        = fail_q;
        fail_addr_d   = fail_addr_q;
        fail_elem_d   = fail_elem_q;
        fail_data_d   = fail_data_q;
        if (start_accept) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_data_d = '0;
        end else if (mismatch && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = chk_addr_q;
            fail_elem_d = chk_elem_q;
            fail_data_d = mem_data_out;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign fail_addr   = fail_addr_q;
    assign fail_elem   = fail_elem_q;
    assign fail_data   = fail_data_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: doc/march_bist_ctrl.md
# march_bist_ctrl

March C- built-in self-test controller that sits directly upstream of the single-port `memory` block. It drives `memory`'s `read`, `write`, `address` and `data_in` ports, and checks `data_out` against expected values. It reports completion, pass/fail status and the first failing location. It issues one memory operation per cycle and accounts for the memory's one-cycle registered read latency.

## Interface
- `a_width`, 4, address width; matches `memory.a_width`.
- `width`, 4, data width; matches `memory.width`.
- `depth`, 16, number of addresses tested (0..depth-1); 2 ≤ depth ≤ 2**a_width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low. Release is synchronous to `clk` externally.
- `start`  in  1  begin a test; sampled only in IDLE or DONE.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until the next start or reset.
- `fail`  out  1  sticky; one or more read mismatches occurred in this run.
- `fail_addr`  out  a_width  address of the first mismatch.
- `fail_elem`  out  3  March element (0..5) of the first mismatch.
- `fail_data`  out  width  data read at the first mismatch.
- `mem_read`  out  1  to `memory.read`.
- `mem_write`  out  1  to `memory.write`.
- `mem_address`  out  a_width  to `memory.address`.
- `mem_data_in`  out  width  to `memory.data_in`.
- `mem_data_out`  in  width  from `memory.data_out`.

## Operation
- States: IDLE → RUN → DRAIN → DONE → (start) → RUN.
- In IDLE or DONE, `start`=1 at a rising edge has three effects:
  - clears `done`, `fail` and the `fail_*` outputs;
  - loads element 0 with the address set to its first value;
  - enters RUN.
- `start` is ignored in RUN and DRAIN.
- March C- elements; ⇑ runs addresses 0→depth-1, ⇓ runs depth-1→0, ⇕ uses ⇑:
  - 0: ⇕ w0
  - 1: ⇑ r0,w1
  - 2: ⇑ r1,w0
  - 3: ⇓ r0,w1
  - 4: ⇓ r1,w0
  - 5: ⇕ r0
- Data patterns: "0" is all zeros and "1" is all ones, on `width` bits.
- Two-op elements issue the read, then the write to the same address on the next cycle, then advance the address.
- At most one of `mem_read` and `mem_write` is high in any cycle. Both are low outside RUN.
- Check pipeline:
  - Each issued read registers expected data, address and element, plus a valid flag.
  - On the following cycle, `mem_data_out` is compared to the expected data.
  - On a mismatch with `fail`=0: set `fail` and capture `fail_addr`, `fail_elem` and `fail_data`.
  - Later mismatches set nothing new; the run always completes.
- DRAIN lasts one cycle. It performs the compare for the final read of element 5, then enters DONE.
- Address counter:
  - Widths are exact, with no wrap beyond depth-1 and no overflow.
  - The element advances when the last address of the element completes its final op.
  - The down counter terminates at 0 without underflow.

## Timing
- Every output is registered.
- Reset values: every output is 0, and the state is IDLE.
- Reset asserted mid-run forces IDLE and all outputs to 0 immediately. The memory strobes drop without waiting for a clock edge.
- Edge E0 samples `start`. During the next cycle, `busy`=1 and the first op (write addr 0, data 0) is on the `mem_*` outputs.
- RUN lasts exactly 10·depth cycles. That is 5·depth writes and 5·depth reads.
- DRAIN is 1 cycle, so `busy` is high for 10·depth+1 cycles in total.
- `done` rises in the same cycle that `busy` falls.
- A read issued in cycle N is compared in cycle N+1. `fail` is visible in cycle N+2.

## Test plan
- **Fault-free memory, depth=16:**
  - `busy` is high for 161 cycles, then `done`=1 and `fail`=0.
  - The bench counts 80 writes and 80 reads, with never both strobes high together.
- **Stuck-at-1 on bit 0 of address 5:**
  - `fail`=1, `fail_elem`=1, `fail_addr`=5, `fail_data`=4'b0001.
  - `done` is still reached after 161 busy cycles.
- **Stuck-at-0 on bit 3 of address 15:** `fail_elem`=2, `fail_addr`=15, `fail_data`=4'b0111.
- **Decoder fault where writes to address 7 also write address 3:** `fail_elem`=3, `fail_addr`=3, `fail_data`=4'b1111.
- **Pulse `start` mid-run:**
  - The pulse is ignored and the run length is unchanged.
  - A fresh `start` in DONE clears `fail` and `done` and reruns cleanly.
- **Assert `rst_n`=0 mid-element 3:**
  - `mem_read`, `mem_write`, `busy` and `fail` go to 0 before the next edge.
  - A new `start` after release completes a full 161-cycle run.
